// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// The master issues one access at a time; the slave answers with a one-cycle
// rsp_valid strobe.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-outstanding byte/half/word load/store onto a
// 32-bit word array, with WAIT_STATES programmable latency.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned or size-11 accesses fault
// (rsp_err) instead of being force-aligned.

// Per byte-lane write enable and write byte for one access.
module data_mem_ctrl_lane #(
  parameter int LANE   = 0,
  parameter int LANE_W = 8
) (
  input  logic [1:0]        size,
  input  logic [1:0]        sel,
  input  logic [31:0]       wdata,
  output logic              be,
  output logic [LANE_W-1:0] wbyte
);
  localparam logic [1:0] LID = 2'(LANE);

  // Byte hits one lane, half hits the lane pair picked by sel[1], word all.
  always_comb begin
    be    = 1'b1;
    wbyte = wdata[LANE_W*LANE +: LANE_W];
    case (size)
      2'b00: begin
        be    = (sel == LID);
        wbyte = wdata[LANE_W-1:0];
      end
      2'b01: begin
        be    = (sel[1] == LID[1]);
        wbyte = wdata[LANE_W*(LANE%2) +: LANE_W];
      end
      default: ;
    endcase
  end
endmodule

module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  data_mem_ctrl_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DEPTH     = 1 << (ADDR_WIDTH - 2);
  localparam int CNT_INIT  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  // Contents are deliberately never reset.
  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  req_t        req_q, req_d;

  req_t                             live, cur;
  logic                             accept, enter_resp, mis_err, wr_en;
  logic [1:0]                       eff_size;
  logic [ADDR_WIDTH-1:0]            eff_addr;
  logic [ADDR_WIDTH-3:0]            widx;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_word, wl;
  logic [NUM_LANES-1:0]             be;
  logic [7:0]                       ld_b;
  logic [15:0]                      ld_h;
  logic [31:0]                      ld_data;

  assign live   = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                    addr: bus.req_addr, wdata: bus.req_wdata};
  assign accept = bus.req_valid & ready_q;
  // With zero wait states the access completes on its accept edge, so the
  // live request fields drive the datapath while in IDLE.
  assign cur    = (state_q == IDLE) ? live : req_q;

  assign enter_resp = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  // Size/alignment decode: fault on misalignment, or silently align.
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    eff_size = cur.size;
    eff_addr = cur.addr;
    mis_err  = (cur.size == 2'b11) ||
               ((cur.size == 2'b01) && cur.addr[0]) ||
               ((cur.size == 2'b10) && (cur.addr[1:0] != 2'b00));
`else
    eff_size = (cur.size == 2'b11) ? 2'b10 : cur.size;
    eff_addr = cur.addr;
    mis_err  = 1'b0;
    if (eff_size == 2'b01) eff_addr[0]   = 1'b0;
    if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
  end

  assign widx    = eff_addr[ADDR_WIDTH-1:2];
  assign rd_word = mem[widx];
  assign wr_en   = enter_resp & cur.we & ~mis_err & rstn;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    data_mem_ctrl_lane #(.LANE(k), .LANE_W(LANE_W)) u_lane (
      .size  (eff_size),
      .sel   (eff_addr[1:0]),
      .wdata (cur.wdata),
      .be    (be[k]),
      .wbyte (wl[k])
    );
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    ld_b = rd_word[eff_addr[1:0]];
    ld_h = eff_addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    case (eff_size)
      2'b00:   ld_data = {{24{~cur.uns & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{~cur.uns & ld_h[15]}}, ld_h};
      default: ld_data = rd_word;
    endcase
  end

  // Next-state and registered-output logic of the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = live;
          ready_d = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = mis_err;
      rsp_rdata_d = (cur.we || mis_err) ? 32'd0 : ld_data;
    end
  end

  // Sequencer state and response registers; reset drops any pending access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit on the edge entering RESP, only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (be[k]) mem[widx][k] <= wl[k];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
